// File: rtl/rx_alu_sequencer_pkg.sv
// Shared definitions for the UART <-> ALU byte sequencer: data widths common
// with the rx, tx and ALU blocks, the one-hot state encodings and a helper
// for sizing the inactivity counter.
package rx_alu_sequencer_pkg;

  localparam int WIDTH_WORD_DEF     = 8;
  localparam int LEN_DATA_DEF       = 8;
  localparam int LEN_OPCODE_DEF     = 6;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

  // One-hot sequencer states
  typedef enum logic [5:0] {
    STATE_WAIT_A  = 6'b000001,
    STATE_WAIT_B  = 6'b000010,
    STATE_WAIT_OP = 6'b000100,
    STATE_EXEC    = 6'b001000,
    STATE_SEND    = 6'b010000,
    STATE_WAIT_TX = 6'b100000
  } state_t;

  // Counter width able to hold TIMEOUT_CYCLES-1, never narrower than one bit
  function automatic int cnt_width(input int cycles);
    if (cycles > 1) begin
      return $clog2(cycles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rx_alu_sequencer_edge_detect_pos.sv
// 1-bit rising-edge detector. The pulse is combinational from the current
// level and the level registered on the previous clock, so a level held high
// for many clocks produces exactly one pulse on its first cycle.
module edge_detect_pos (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_edge
);

  logic prev_r;

  // Remember last cycle's level; cleared by synchronous active-low reset
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= i_level;
    end
  end

  assign o_edge = i_level & ~prev_r;

endmodule

// File: rtl/rx_alu_sequencer.sv
// Byte sequencer between the UART receiver/transmitter and the ALU.
// Collects operand A, operand B and opcode from successive received bytes,
// lets the ALU settle for one cycle, registers the result and strobes the
// transmitter, then waits for the transmitter to finish. An inactivity
// timeout returns a stalled sequence to WAIT_A, and bytes arriving while the
// block is busy are discarded with a drop pulse.
module rx_alu_sequencer
  import rx_alu_sequencer_pkg::*;
#(
  parameter int WIDTH_WORD     = WIDTH_WORD_DEF,
  parameter int LEN_DATA       = LEN_DATA_DEF,
  parameter int LEN_OPCODE     = LEN_OPCODE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [WIDTH_WORD-1:0] i_data_rx,
  input  logic                  i_tx_done,
  input  logic [LEN_DATA-1:0]   i_alu_result,
  output logic [LEN_DATA-1:0]   o_operand_a,
  output logic [LEN_DATA-1:0]   o_operand_b,
  output logic [LEN_OPCODE-1:0] o_opcode,
  output logic                  o_tx_start,
  output logic [WIDTH_WORD-1:0] o_data_tx,
  output logic                  o_timeout,
  output logic                  o_drop
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  state_t           state_r;
  state_t           state_next_s;
  logic             rx_evt_s;
  logic             tx_evt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_hit_s;
  logic             count_en_s;
  logic             timeout_s;
  logic             drop_s;
  logic             cap_a_s;
  logic             cap_b_s;
  logic             cap_op_s;
  logic             exec_s;

  edge_detect_pos u_rx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (i_rx_done),
    .o_edge  (rx_evt_s)
  );

  edge_detect_pos u_tx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (i_tx_done),
    .o_edge  (tx_evt_s)
  );

  assign cnt_hit_s = (cnt_r == CNT_LAST);

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_r <= STATE_WAIT_A;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a byte/tx event always beats a timeout in the same cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      STATE_WAIT_A: begin
        if (rx_evt_s) begin
          state_next_s = STATE_WAIT_B;
        end else begin
          state_next_s = STATE_WAIT_A;
        end
      end
      STATE_WAIT_B: begin
        if (rx_evt_s) begin
          state_next_s = STATE_WAIT_OP;
        end else if (cnt_hit_s) begin
          state_next_s = STATE_WAIT_A;
        end else begin
          state_next_s = STATE_WAIT_B;
        end
      end
      STATE_WAIT_OP: begin
        if (rx_evt_s) begin
          state_next_s = STATE_EXEC;
        end else if (cnt_hit_s) begin
          state_next_s = STATE_WAIT_A;
        end else begin
          state_next_s = STATE_WAIT_OP;
        end
      end
      STATE_EXEC: begin
        state_next_s = STATE_SEND;
      end
      STATE_SEND: begin
        state_next_s = STATE_WAIT_TX;
      end
      STATE_WAIT_TX: begin
        if (tx_evt_s) begin
          state_next_s = STATE_WAIT_A;
        end else if (cnt_hit_s) begin
          state_next_s = STATE_WAIT_A;
        end else begin
          state_next_s = STATE_WAIT_TX;
        end
      end
      default: begin
        state_next_s = STATE_WAIT_A;
      end
    endcase
  end

  // Per-state decode of captures, counting, timeout and drop conditions
  always_comb begin
    cap_a_s    = 1'b0;
    cap_b_s    = 1'b0;
    cap_op_s   = 1'b0;
    exec_s     = 1'b0;
    count_en_s = 1'b0;
    timeout_s  = 1'b0;
    drop_s     = 1'b0;
    case (state_r)
      STATE_WAIT_A: begin
        cap_a_s = rx_evt_s;
      end
      STATE_WAIT_B: begin
        cap_b_s    = rx_evt_s;
        count_en_s = 1'b1;
        timeout_s  = cnt_hit_s & ~rx_evt_s;
      end
      STATE_WAIT_OP: begin
        cap_op_s   = rx_evt_s;
        count_en_s = 1'b1;
        timeout_s  = cnt_hit_s & ~rx_evt_s;
      end
      STATE_EXEC: begin
        exec_s = 1'b1;
        drop_s = rx_evt_s;
      end
      STATE_SEND: begin
        drop_s = rx_evt_s;
      end
      STATE_WAIT_TX: begin
        count_en_s = 1'b1;
        timeout_s  = cnt_hit_s & ~tx_evt_s;
        drop_s     = rx_evt_s;
      end
      default: begin
        cap_a_s = 1'b0;
      end
    endcase
  end

  // Inactivity counter: restarts on every state change, runs only while waiting
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cnt_r <= CNT_ZERO;
    end else if (state_next_s != state_r) begin
      cnt_r <= CNT_ZERO;
    end else if (count_en_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // Registered outputs: operand/opcode/result hold until recaptured, strobes last one cycle
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_operand_a <= {LEN_DATA{1'b0}};
      o_operand_b <= {LEN_DATA{1'b0}};
      o_opcode    <= {LEN_OPCODE{1'b0}};
      o_data_tx   <= {WIDTH_WORD{1'b0}};
      o_tx_start  <= 1'b0;
      o_timeout   <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      if (cap_a_s) begin
        o_operand_a <= i_data_rx[LEN_DATA-1:0];
      end
      if (cap_b_s) begin
        o_operand_b <= i_data_rx[LEN_DATA-1:0];
      end
      if (cap_op_s) begin
        o_opcode <= i_data_rx[LEN_OPCODE-1:0];
      end
      if (exec_s) begin
        o_data_tx <= WIDTH_WORD'(i_alu_result);
      end
      o_tx_start <= (state_next_s == STATE_SEND);
      o_timeout  <= timeout_s;
      o_drop     <= drop_s;
    end
  end

endmodule
